updown_counter_param: RTL

- Parametrised successor of the 8-bit load/up/down counter used by the CPU sequencing logic (loop counters, stack pointer, timer ticks).
- Adds configurable width, modulus, variable step, count enable, wrap or saturate mode, and terminal/event flags.
- Single clock domain; drops in wherever a loadable counter with status outputs is needed.

---
 rtl/updown_counter_param.sv | 138 +++++++++++++
 1 files changed

// File: rtl/updown_counter_param.sv
// updown_counter_param
//   Loadable up/down counter with configurable width and modulus, a
//   variable step, a count enable, wrap or saturate mode, and status flags.
//   Optional snapshot register is built only when the macro
//   UPDOWN_COUNTER_SNAPSHOT_EN is defined.
//
// Parameters
//   WIDTH     bit width of count, load value and step
//   MAXVAL    highest legal count (1 <= MAXVAL <= 2**WIDTH-1)
//   SATURATE  0 = wrap modulo MAXVAL+1, 1 = clamp at 0 / MAXVAL
//
// Ports
//   clock            rising-edge clock
//   reset            synchronous, active-low reset
//   enable           count enable
//   decrement        1 = count down, 0 = count up
//   step             amount per enabled cycle (values above MAXVAL act as MAXVAL)
//   setvalue         synchronous load of valuein (clamped to MAXVAL)
//   valuein          load value
//   clearflags       clears overflow_sticky
//   valueout         registered count
//   zero             valueout == 0
//   atmax            valueout == MAXVAL
//   event_pulse      one-cycle pulse after a wrap or saturation event
//   overflow_sticky  set by any event, held until cleared
//   capture          (snapshot build) copy pre-update valueout into snapshot
//   snapshot         (snapshot build) captured value
module updown_counter_param #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned MAXVAL   = 2**WIDTH-1,
  parameter bit          SATURATE = 1'b0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             decrement,
  input  logic [WIDTH-1:0] step,
  input  logic             setvalue,
  input  logic [WIDTH-1:0] valuein,
  input  logic             clearflags,
  output logic [WIDTH-1:0] valueout,
  output logic             zero,
  output logic             atmax,
  output logic             event_pulse,
  output logic             overflow_sticky
`ifdef UPDOWN_COUNTER_SNAPSHOT_EN
  ,
  input  logic             capture,
  output logic [WIDTH-1:0] snapshot
`endif
);

  localparam logic [WIDTH:0]   MAX_EXT = (WIDTH+1)'(MAXVAL);
  localparam logic [WIDTH-1:0] MAX_V   = MAX_EXT[WIDTH-1:0];

  logic [WIDTH-1:0] valueout_q, valueout_d;
  logic             event_pulse_q, event_pulse_d;
  logic             overflow_sticky_q, overflow_sticky_d;

  logic [WIDTH:0] v_ext, s_ext, sum_ext, diff_ext;
  logic [WIDTH:0] wrap_up_ext, wrap_dn_ext;

  // All arithmetic is one bit wider than the count so the overflow
  // comparison sees the untruncated result.
  always_comb begin
    v_ext       = {1'b0, valueout_q};
    s_ext       = ({1'b0, step} > MAX_EXT) ? MAX_EXT : {1'b0, step};
    sum_ext     = v_ext + s_ext;
    diff_ext    = v_ext - s_ext;
    wrap_up_ext = sum_ext - MAX_EXT - 1'b1;
    wrap_dn_ext = v_ext + MAX_EXT + 1'b1 - s_ext;
  end

  always_comb begin
    valueout_d    = valueout_q;
    event_pulse_d = 1'b0;
    if (setvalue) begin
      valueout_d = (valuein > MAX_V) ? MAX_V : valuein;
    end else if (enable) begin
      if (!decrement) begin
        if (sum_ext > MAX_EXT) begin
          event_pulse_d = 1'b1;
          valueout_d    = SATURATE ? MAX_V : wrap_up_ext[WIDTH-1:0];
        end else begin
          valueout_d = sum_ext[WIDTH-1:0];
        end
      end else begin
        if (s_ext > v_ext) begin
          event_pulse_d = 1'b1;
          valueout_d    = SATURATE ? '0 : wrap_dn_ext[WIDTH-1:0];
        end else begin
          valueout_d = diff_ext[WIDTH-1:0];
        end
      end
    end
    // A new event always wins over a same-edge clear.
    if (event_pulse_d)   overflow_sticky_d = 1'b1;
    else if (clearflags) overflow_sticky_d = 1'b0;
    else                 overflow_sticky_d = overflow_sticky_q;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      valueout_q        <= '0;
      event_pulse_q     <= 1'b0;
      overflow_sticky_q <= 1'b0;
    end else begin
      valueout_q        <= valueout_d;
      event_pulse_q     <= event_pulse_d;
      overflow_sticky_q <= overflow_sticky_d;
    end
  end

  assign valueout        = valueout_q;
  assign event_pulse     = event_pulse_q;
  assign overflow_sticky = overflow_sticky_q;
  assign zero            = (valueout_q == '0);
  assign atmax           = (valueout_q == MAX_V);

`ifdef UPDOWN_COUNTER_SNAPSHOT_EN
  logic [WIDTH-1:0] snapshot_q, snapshot_d;

  // Captures the value held before this edge, independent of load/count.
  always_comb begin
    snapshot_d = capture ? valueout_q : snapshot_q;
  end

  always_ff @(posedge clock) begin
    if (!reset) snapshot_q <= '0;
    else        snapshot_q <= snapshot_d;
  end

  assign snapshot = snapshot_q;
`else
  // No snapshot register in this build.
`endif

endmodule
